inst_encoder: RTL and testbench
===============================

# inst_encoder

Instruction encoder for the fetch/decode pipeline: packs an opcode class, register fields, funct3 and a signed 32-bit immediate into a 32-bit RV32I instruction word. It covers the same formats the decoder's immediate generator expands: I-type loads and OP-IMM, S-type stores and B-type branches. It sits between the boot/test program sequencer and the instruction-memory write port. Each output word carries a byte address from an internal running counter, so the stream can be written to instruction memory directly.

## Interface
- ADDR_W, 32: width of the word address counter / out_addr.
- BASE_ADDR, 0: address given to the first word after reset or clear; must be a multiple of 4.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous; reloads address counter to BASE_ADDR.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder can accept a request this cycle.
- in_op  in  5  opcode bits [6:2] of the target instruction; bits [1:0] are always 2'b11.
- in_rd  in  5  destination register (I only).
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2 (S/B only).
- in_funct3  in  3  funct3 field.
- in_imm  in  32  signed immediate (byte offset for B).
- out_valid  out  1  encoded word valid.
- out_ready  in  1  consumer accepts word.
- out_inst  out  32  encoded instruction.
- out_addr  out  ADDR_W  byte address of out_inst.
- out_err  out  1  request was illegal; out_inst is NOP 0x00000013.
- err_count  out  8  number of illegal requests, saturating at 255.

## Operation
- Supported in_op values:
  - 5'b00000 (load) and 5'b00100 (OP-IMM): I format.
  - 5'b01000 (store): S format.
  - 5'b11000 (branch): B format.
  - Any other in_op is illegal.
- I format:
  - Fields: [31:20]=imm[11:0], [19:15]=rs1, [14:12]=funct3, [11:7]=rd, [6:0]={op,2'b11}.
  - Legal immediate range: -2048..2047.
- S format:
  - Fields: [31:25]=imm[11:5], [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:7]=imm[4:0].
  - Legal immediate range: -2048..2047.
- B format:
  - Fields: [31]=imm[12], [30:25]=imm[10:5], [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:8]=imm[4:1], [7]=imm[11].
  - Legal immediate range: -4096..4094, and imm[0] must be 0.
- Range checks are signed and use the full 32-bit in_imm.
- Illegal request (bad op, immediate out of range, or odd B offset):
  - The request is still consumed and still produces one output word.
  - out_inst=0x00000013, out_err=1.
  - err_count increments (saturating at 255).
  - The address is consumed like a legal word.
- Ignored fields: in_rd is ignored for S/B; in_rs2 is ignored for I.
- Two-stage pipeline:
  - Stage 0 registers the request, its assigned address and the legality result.
  - Stage 1 holds the encoded word.
- Address counter:
  - Each accepted request (in_valid && in_ready) takes the current counter value as its address; the counter then advances by 4.
  - The counter wraps modulo 2^ADDR_W.
  - clear without an accept: counter becomes BASE_ADDR.
  - clear in the same cycle as an accept: the accepted request takes BASE_ADDR, and the counter becomes BASE_ADDR+4.
- clear does not flush words already in the pipeline and does not reset err_count.

## Timing
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_inst=0, out_addr=0, out_err=0, err_count=0.
  - Address counter = BASE_ADDR; both pipeline stages empty.
  - in_ready=1 once rst_n is high.
- Reset asserted mid-operation discards all in-flight words; no partial word appears after release.
- Latency: a request accepted in cycle N appears on out_valid/out_inst in cycle N+2 when there is no backpressure.
- Throughput: one word per cycle.
- in_ready = !stage1_valid || out_ready || !stage0_valid. This is a combinational ready path; there is no bubble while out_ready is high.
- Stage advance rules:
  - Stage 1 loads from stage 0 when stage 1 is empty or out_ready=1.
  - Stage 0 loads when stage 0 is empty or moving to stage 1.
- Capacity: 2 words. With out_ready held low, in_ready falls after two accepts.
- out_inst, out_addr and out_err stay stable while out_valid && !out_ready.
- out_valid does not drop without a handshake.
- err_count updates in the cycle an illegal request is accepted.

## Test plan
- addi x1,x0,5: op=00100, rd=1, rs1=0, f3=0, imm=5 -> out_inst=0x00500093, out_err=0, out_addr=BASE_ADDR, two cycles after accept.
- Back-to-back lw x2,-4(x3) / sw x5,8(x2) / beq x1,x2,-8 with out_ready=1:
  - Outputs on consecutive cycles: 0xFFC1A103, 0x00512423, 0xFE208CE3.
  - Addresses 0, 4, 8.
- Illegal requests: addi imm=2048, then beq imm=3, then op=01100:
  - Three words, each 0x00000013 with out_err=1.
  - err_count=3; addresses continue incrementing.
- Backpressure: out_ready=0 for 6 cycles while in_valid=1 with 4 distinct requests:
  - in_ready low after 2 accepts; outputs held stable.
  - On release, all 4 words emerge in order with no loss or duplication.
- Wrap and clear:
  - ADDR_W=4, BASE_ADDR=8: addresses run 8, 12, 0, 4.
  - clear pulsed together with an accept gives that word address 8, and the next word 12.
- Reset: assert rst_n low with 2 words in flight:
  - out_valid=0 immediately, err_count=0.
  - First word after release gets BASE_ADDR.

Source files
------------

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs I/S/B-format fields into a 32-bit word through a
// two-stage valid/ready pipeline, tagging each word with a running byte address.
module inst_encoder #(
    parameter int          ADDR_W    = 32,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [7:0]        err_count
);

    localparam logic [4:0]        LP_OP_LOAD   = 5'b00000;
    localparam logic [4:0]        LP_OP_OPIMM  = 5'b00100;
    localparam logic [4:0]        LP_OP_STORE  = 5'b01000;
    localparam logic [4:0]        LP_OP_BRANCH = 5'b11000;
    localparam logic [31:0]       LP_NOP       = 32'h0000_0013;
    localparam logic [ADDR_W-1:0] LP_BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LP_STEP      = ADDR_W'(4);

    logic [ADDR_W-1:0] r_addr;

    logic              r_s0_valid;
    logic              r_s0_err;
    logic [4:0]        r_s0_op;
    logic [4:0]        r_s0_rd;
    logic [4:0]        r_s0_rs1;
    logic [4:0]        r_s0_rs2;
    logic [2:0]        r_s0_funct3;
    logic [12:0]       r_s0_imm;
    logic [ADDR_W-1:0] r_s0_addr;

    logic              r_out_valid;
    logic [31:0]       r_out_inst;
    logic [ADDR_W-1:0] r_out_addr;
    logic              r_out_err;
    logic [7:0]        r_err_count;

    logic signed [31:0] w_imm_s;
    logic               w_is_i;
    logic               w_is_s;
    logic               w_is_b;
    logic               w_imm12_ok;
    logic               w_imm13_ok;
    logic               w_legal;
    logic               w_s1_free;
    logic               w_s0_load;
    logic               w_accept;
    logic [ADDR_W-1:0]  w_cur_addr;
    logic [31:0]        w_enc;

    assign w_imm_s    = in_imm;
    assign w_is_i     = (in_op == LP_OP_LOAD) || (in_op == LP_OP_OPIMM);
    assign w_is_s     = (in_op == LP_OP_STORE);
    assign w_is_b     = (in_op == LP_OP_BRANCH);
    assign w_imm12_ok = (w_imm_s >= -32'sd2048) && (w_imm_s <= 32'sd2047);
    assign w_imm13_ok = (w_imm_s >= -32'sd4096) && (w_imm_s <= 32'sd4094) && !in_imm[0];
    assign w_legal    = ((w_is_i || w_is_s) && w_imm12_ok) || (w_is_b && w_imm13_ok);

    // Ready depends on out_ready combinationally so a full pipe still streams at one word per cycle.
    assign w_s1_free  = !r_out_valid || out_ready;
    assign w_s0_load  = !r_s0_valid || w_s1_free;
    assign in_ready   = w_s0_load;
    assign w_accept   = in_valid && w_s0_load;
    assign w_cur_addr = clear ? LP_BASE : r_addr;

    always_comb begin
        w_enc = LP_NOP;
        if (!r_s0_err) begin
            case (r_s0_op)
                LP_OP_LOAD, LP_OP_OPIMM:
                    w_enc = {r_s0_imm[11:0], r_s0_rs1, r_s0_funct3, r_s0_rd, r_s0_op, 2'b11};
                LP_OP_STORE:
                    w_enc = {r_s0_imm[11:5], r_s0_rs2, r_s0_rs1, r_s0_funct3,
                             r_s0_imm[4:0], r_s0_op, 2'b11};
                LP_OP_BRANCH:
                    w_enc = {r_s0_imm[12], r_s0_imm[10:5], r_s0_rs2, r_s0_rs1, r_s0_funct3,
                             r_s0_imm[4:1], r_s0_imm[11], r_s0_op, 2'b11};
                default:
                    w_enc = LP_NOP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= LP_BASE;
        end else if (w_accept) begin
            r_addr <= w_cur_addr + LP_STEP;
        end else if (clear) begin
            r_addr <= LP_BASE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s0_valid  <= 1'b0;
            r_s0_err    <= 1'b0;
            r_s0_op     <= '0;
            r_s0_rd     <= '0;
            r_s0_rs1    <= '0;
            r_s0_rs2    <= '0;
            r_s0_funct3 <= '0;
            r_s0_imm    <= '0;
            r_s0_addr   <= '0;
        end else if (w_s0_load) begin
            r_s0_valid <= w_accept;
            if (w_accept) begin
                r_s0_err    <= !w_legal;
                r_s0_op     <= in_op;
                r_s0_rd     <= in_rd;
                r_s0_rs1    <= in_rs1;
                r_s0_rs2    <= in_rs2;
                r_s0_funct3 <= in_funct3;
                r_s0_imm    <= in_imm[12:0];
                r_s0_addr   <= w_cur_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_inst  <= '0;
            r_out_addr  <= '0;
            r_out_err   <= 1'b0;
        end else if (w_s1_free) begin
            r_out_valid <= r_s0_valid;
            if (r_s0_valid) begin
                r_out_inst <= w_enc;
                r_out_addr <= r_s0_addr;
                r_out_err  <= r_s0_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (w_accept && !w_legal && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign out_valid = r_out_valid;
    assign out_inst  = r_out_inst;
    assign out_addr  = r_out_addr;
    assign out_err   = r_out_err;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: a 4-bit/base-8 instance exercises wrap and clear,
// a default 32-bit/base-0 instance runs the same stream in parallel.
module tb_inst_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [4:0]  in_op = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [31:0] in_imm = '0;
    logic        out_ready = 1'b1;

    logic        in_ready, out_valid, out_err;
    logic [31:0] out_inst;
    logic [3:0]  out_addr;
    logic [7:0]  err_count;

    logic        b_in_ready, b_out_valid, b_out_err;
    logic [31:0] b_out_inst;
    logic [31:0] b_out_addr;
    logic [7:0]  b_err_count;

    int n_total = 0;
    int n_bad = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] inst;
        logic        err;
        logic [3:0]  addr_a;
        logic [31:0] addr_b;
        int          cyc;
        logic        lat;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] g_exp_inst = '0;
    logic        g_exp_err = 1'b0;
    logic        g_lat = 1'b1;
    logic [3:0]  m_addr_a = 4'd8;
    logic [31:0] m_addr_b = 32'd0;
    logic        hold_v = 1'b0;
    logic [31:0] hold_inst;
    logic [3:0]  hold_addr;
    logic        hold_err;

    inst_encoder #(.ADDR_W(4), .BASE_ADDR(8)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_addr(out_addr), .out_err(out_err),
        .err_count(err_count)
    );

    inst_encoder dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_imm(in_imm),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_inst(b_out_inst), .out_addr(b_out_addr), .out_err(b_out_err),
        .err_count(b_err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Monitor: samples 1 time unit after the falling edge, ahead of the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        logic [3:0]  a;
        logic [31:0] b;
        #1;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk_eq("unexpected_word", {31'd0, out_valid}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk_eq("inst", out_inst, e.inst);
                    chk_eq("err", {31'd0, out_err}, {31'd0, e.err});
                    chk_eq("addr_a", {28'd0, out_addr}, {28'd0, e.addr_a});
                    chk_eq("addr_b", b_out_addr, e.addr_b);
                    chk_eq("inst_b", b_out_inst, e.inst);
                    chk_eq("valid_b", {31'd0, b_out_valid}, 32'd1);
                    if (e.lat) chk_eq("latency", cyc - e.cyc, 32'd2);
                end
            end
            if (hold_v) begin
                chk_eq("hold_valid", {31'd0, out_valid}, 32'd1);
                chk_eq("hold_inst", out_inst, hold_inst);
                chk_eq("hold_addr", {28'd0, out_addr}, {28'd0, hold_addr});
                chk_eq("hold_err", {31'd0, out_err}, {31'd0, hold_err});
            end
            hold_v    = out_valid && !out_ready;
            hold_inst = out_inst;
            hold_addr = out_addr;
            hold_err  = out_err;
            if (in_valid && in_ready) begin
                chk_eq("ready_b", {31'd0, b_in_ready}, 32'd1);
                a = clear ? 4'd8 : m_addr_a;
                b = clear ? 32'd0 : m_addr_b;
                m_addr_a = a + 4'd4;
                m_addr_b = b + 32'd4;
                e.inst   = g_exp_inst;
                e.err    = g_exp_err;
                e.addr_a = a;
                e.addr_b = b;
                e.cyc    = cyc;
                e.lat    = g_lat;
                sb_q.push_back(e);
            end else if (clear) begin
                m_addr_a = 4'd8;
                m_addr_b = 32'd0;
            end
        end
    end

    task automatic send(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm,
                        input logic [31:0] ei, input logic ee, input logic clr);
        int n = 0;
        @(negedge clk);
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_funct3 = f3; in_imm = imm;
        g_exp_inst = ei; g_exp_err = ee;
        clear = clr;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) chk_eq("send_timeout", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic idle(input logic clr);
        @(negedge clk);
        in_valid = 1'b0;
        clear = clr;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        #2;
        chk_eq("drain_empty", sb_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #7;
        chk_eq("rst_valid", {31'd0, out_valid}, 32'd0);
        chk_eq("rst_inst", out_inst, 32'd0);
        chk_eq("rst_addr", {28'd0, out_addr}, 32'd0);
        chk_eq("rst_err", {31'd0, out_err}, 32'd0);
        chk_eq("rst_errcnt", {24'd0, err_count}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_eq("rst_ready", {31'd0, in_ready}, 32'd1);

        // addi x1,x0,5
        send(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 32'h0050_0093, 1'b0, 1'b0);
        idle(1'b0);
        drain();

        // lw x2,-4(x3) / sw x5,8(x2) / beq x1,x2,-8 back to back
        send(5'b00000, 5'd2, 5'd3, 5'd0, 3'd2, 32'hFFFF_FFFC, 32'hFFC1_A103, 1'b0, 1'b0);
        send(5'b01000, 5'd0, 5'd2, 5'd5, 3'd2, 32'd8, 32'h0051_2423, 1'b0, 1'b0);
        send(5'b11000, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFF_FFF8, 32'hFE20_8CE3, 1'b0, 1'b0);
        idle(1'b0);
        drain();

        // Range edges and ignored fields
        send(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2047, 32'h7FF0_0093, 1'b0, 1'b0);
        send(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_F800, 32'h8000_0093, 1'b0, 1'b0);
        send(5'b01000, 5'd31, 5'd2, 5'd5, 3'd2, 32'hFFFF_F800, 32'h8051_2023, 1'b0, 1'b0);
        send(5'b11000, 5'd0, 5'd1, 5'd2, 3'd0, 32'd4094, 32'h7E20_8FE3, 1'b0, 1'b0);
        send(5'b11000, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFF_F000, 32'h8020_8063, 1'b0, 1'b0);
        send(5'b00100, 5'd1, 5'd0, 5'd31, 3'd0, 32'd5, 32'h0050_0093, 1'b0, 1'b0);
        idle(1'b0);
        drain();

        // Illegal requests
        send(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 32'h0000_0013, 1'b1, 1'b0);
        send(5'b11000, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3, 32'h0000_0013, 1'b1, 1'b0);
        send(5'b01100, 5'd1, 5'd2, 5'd3, 3'd0, 32'd0, 32'h0000_0013, 1'b1, 1'b0);
        idle(1'b0);
        drain();
        chk_eq("errcnt_3", {24'd0, err_count}, 32'd3);
        chk_eq("errcnt_3_b", {24'd0, b_err_count}, 32'd3);
        send(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_F7FF, 32'h0000_0013, 1'b1, 1'b0);
        send(5'b11000, 5'd0, 5'd1, 5'd2, 3'd0, 32'd4096, 32'h0000_0013, 1'b1, 1'b0);
        send(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 32'h1000_0005, 32'h0000_0013, 1'b1, 1'b0);
        idle(1'b0);
        drain();
        chk_eq("errcnt_6", {24'd0, err_count}, 32'd6);
        for (int i = 0; i < 255; i++) begin
            send(5'b01100, 5'd1, 5'd2, 5'd3, 3'd0, 32'd0, 32'h0000_0013, 1'b1, 1'b0);
        end
        idle(1'b0);
        drain();
        chk_eq("errcnt_sat", {24'd0, err_count}, 32'd255);
        chk_eq("errcnt_sat_b", {24'd0, b_err_count}, 32'd255);

        // Clear alone, then clear together with an accept
        idle(1'b1);
        send(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1, 32'h0010_0093, 1'b0, 1'b0);
        send(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2, 32'h0020_0093, 1'b0, 1'b0);
        send(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 32'd3, 32'h0030_0093, 1'b0, 1'b1);
        send(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 32'd4, 32'h0040_0093, 1'b0, 1'b0);
        idle(1'b0);
        drain();

        // Backpressure: out_ready low for 6 cycles while 4 requests queue up
        g_lat = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        fork
            begin
                send(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1, 32'h0010_0093, 1'b0, 1'b0);
                send(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2, 32'h0020_0093, 1'b0, 1'b0);
                send(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 32'd3, 32'h0030_0093, 1'b0, 1'b0);
                send(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 32'd4, 32'h0040_0093, 1'b0, 1'b0);
                idle(1'b0);
            end
            begin
                repeat (4) @(negedge clk);
                #1;
                chk_eq("bp_ready_low", {31'd0, in_ready}, 32'd0);
                chk_eq("bp_depth", sb_q.size(), 32'd2);
                repeat (2) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();
        g_lat = 1'b1;

        // Reset with two words in flight
        @(negedge clk);
        out_ready = 1'b0;
        send(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1, 32'h0010_0093, 1'b0, 1'b0);
        send(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2, 32'h0020_0093, 1'b0, 1'b0);
        idle(1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk_eq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk_eq("mid_rst_errcnt", {24'd0, err_count}, 32'd0);
        chk_eq("mid_rst_valid_b", {31'd0, b_out_valid}, 32'd0);
        sb_q.delete();
        m_addr_a = 4'd8;
        m_addr_b = 32'd0;
        hold_v = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 32'h0050_0093, 1'b0, 1'b0);
        idle(1'b0);
        drain();
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
